// File: rtl/fm_preemph.sv
// ---------------------------------------------------------------------------
// fm_preemph -- first-order fixed-point pre-emphasis filter for the FM
// transmit path:  y[n] = DEQ(C0*x[n] + C1*x[n-1]).
//
// The filter is a two-stage registered pipeline with full backpressure:
//   stage 1 registers both products and the sample history.
//   stage 2 adds the products, dequantises the sum (truncating toward zero),
//           saturates it and registers the result.
//
// Ports:
//   clock      rising-edge clock
//   reset_n    asynchronous active-low reset
//   din        head word of the upstream show-ahead FIFO (valid when !in_empty)
//   in_empty   upstream FIFO empty
//   in_rd_en   pops the upstream FIFO this cycle
//   dout       filtered sample (registered)
//   out_full   downstream FIFO full
//   out_wr_en  writes dout to the downstream FIFO this cycle
//   sat_flag   sticky flag, set when any output was clamped
// ---------------------------------------------------------------------------
module fm_preemph #(
    parameter int DATA_WIDTH = 32,
    parameter int COEF_WIDTH = 16,
    parameter int FRAC_BITS  = 10,
    parameter int C0         = 1690,
    parameter int C1         = -666
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  in_empty,
    output logic                  in_rd_en,
    output logic [DATA_WIDTH-1:0] dout,
    input  logic                  out_full,
    output logic                  out_wr_en,
    output logic                  sat_flag
);

    localparam int PW = DATA_WIDTH + COEF_WIDTH;  // product width
    localparam int AW = PW + 1;                   // accumulator width

    localparam logic signed [COEF_WIDTH-1:0] C0_K = COEF_WIDTH'(C0);
    localparam logic signed [COEF_WIDTH-1:0] C1_K = COEF_WIDTH'(C1);

    // Adding 2^FRAC_BITS-1 before the arithmetic shift turns the shift's
    // round-toward-minus-infinity into truncation toward zero for negatives.
    localparam logic signed [AW-1:0] BIAS  = {{(AW-FRAC_BITS){1'b0}}, {FRAC_BITS{1'b1}}};
    localparam logic signed [AW-1:0] Q_MAX = {{(AW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [AW-1:0] Q_MIN = {{(AW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    // Dequantise and saturate; result is {clamped, value}.
    function automatic logic [DATA_WIDTH:0] deq_sat(input logic signed [AW-1:0] a);
        logic signed [AW-1:0] q;
        if (a[AW-1]) begin
            q = (a + BIAS) >>> FRAC_BITS;
        end else begin
            q = a >>> FRAC_BITS;
        end
        if (q > Q_MAX) begin
            return {1'b1, Q_MAX[DATA_WIDTH-1:0]};
        end else if (q < Q_MIN) begin
            return {1'b1, Q_MIN[DATA_WIDTH-1:0]};
        end else begin
            return {1'b0, q[DATA_WIDTH-1:0]};
        end
    endfunction

    // Pipeline state
    logic signed [PW-1:0]   p0_q, p0_d;
    logic signed [PW-1:0]   p1_q, p1_d;
    logic [DATA_WIDTH-1:0]  x_prev_q, x_prev_d;
    logic                   s1_valid_q, s1_valid_d;
    logic [DATA_WIDTH-1:0]  dout_q, dout_d;
    logic                   s2_valid_q, s2_valid_d;
    logic                   sat_q, sat_d;

    // Combinational helpers
    logic                   s1_ready;
    logic                   s2_ready;
    logic signed [PW-1:0]   din_ext;
    logic signed [PW-1:0]   x_prev_ext;
    logic signed [PW-1:0]   c0_ext;
    logic signed [PW-1:0]   c1_ext;
    logic signed [AW-1:0]   acc;
    logic [DATA_WIDTH:0]    deq;

    assign din_ext    = {{COEF_WIDTH{din[DATA_WIDTH-1]}}, din};
    assign x_prev_ext = {{COEF_WIDTH{x_prev_q[DATA_WIDTH-1]}}, x_prev_q};
    assign c0_ext     = {{DATA_WIDTH{C0_K[COEF_WIDTH-1]}}, C0_K};
    assign c1_ext     = {{DATA_WIDTH{C1_K[COEF_WIDTH-1]}}, C1_K};
    assign acc        = {p0_q[PW-1], p0_q} + {p1_q[PW-1], p1_q};
    assign deq        = deq_sat(acc);

    // Handshake: derived only from registered state and the FIFO flags.
    assign s2_ready  = !s2_valid_q || !out_full;
    assign s1_ready  = !s1_valid_q || s2_ready;
    assign in_rd_en  = !in_empty && s1_ready;
    assign out_wr_en = s2_valid_q && !out_full;

    assign dout     = dout_q;
    assign sat_flag = sat_q;

    // Stage 1: products and history advance only when a sample is popped.
    always_comb begin
        p0_d       = p0_q;
        p1_d       = p1_q;
        x_prev_d   = x_prev_q;
        s1_valid_d = s1_valid_q;
        if (in_rd_en) begin
            p0_d       = din_ext * c0_ext;
            p1_d       = x_prev_ext * c1_ext;
            x_prev_d   = din;
            s1_valid_d = 1'b1;
        end else if (s1_ready) begin
            s1_valid_d = 1'b0;
        end else begin
            s1_valid_d = s1_valid_q;
        end
    end

    // Stage 2: accumulate, dequantise, saturate; frozen while downstream is full.
    always_comb begin
        dout_d     = dout_q;
        s2_valid_d = s2_valid_q;
        sat_d      = sat_q;
        if (s2_ready) begin
            if (s1_valid_q) begin
                dout_d     = deq[DATA_WIDTH-1:0];
                s2_valid_d = 1'b1;
                sat_d      = sat_q | deq[DATA_WIDTH];
            end else begin
                s2_valid_d = 1'b0;
            end
        end else begin
            s2_valid_d = s2_valid_q;
        end
    end

    // State registers; reset discards in-flight samples and clears history.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            p0_q       <= '0;
            p1_q       <= '0;
            x_prev_q   <= '0;
            s1_valid_q <= 1'b0;
            dout_q     <= '0;
            s2_valid_q <= 1'b0;
            sat_q      <= 1'b0;
        end else begin
            p0_q       <= p0_d;
            p1_q       <= p1_d;
            x_prev_q   <= x_prev_d;
            s1_valid_q <= s1_valid_d;
            dout_q     <= dout_d;
            s2_valid_q <= s2_valid_d;
            sat_q      <= sat_d;
        end
    end

endmodule

// File: tb/tb_fm_preemph.sv
// ---------------------------------------------------------------------------
// tb_fm_preemph -- self-checking bench for fm_preemph. A queue of source
// samples feeds the show-ahead interface; every popped sample is run through
// a plain-arithmetic reference of y = sat(trunc0((1690*x + -666*xprev)/1024))
// and the expected values are matched in order against each write.
// ---------------------------------------------------------------------------
module tb_fm_preemph;

    logic        clock;
    logic        reset_n;
    logic [31:0] din;
    logic        in_empty;
    logic        in_rd_en;
    logic [31:0] dout;
    logic        out_full;
    logic        out_wr_en;
    logic        sat_flag;

    fm_preemph dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .din      (din),
        .in_empty (in_empty),
        .in_rd_en (in_rd_en),
        .dout     (dout),
        .out_full (out_full),
        .out_wr_en(out_wr_en),
        .sat_flag (sat_flag)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        longint val;
        bit     sat;
        int     pop_cyc;
    } exp_t;

    int     n_checks = 0;
    int     n_pass   = 0;
    int     cyc      = 0;
    int     pops     = 0;
    int     writes   = 0;
    bit     bursty   = 1'b0;
    bit     rand_full = 1'b0;
    bit     full_force = 1'b0;
    bit     check_lat = 1'b0;
    bit     sat_exp  = 1'b0;
    longint mx_prev  = 0;
    logic [31:0] src[$];
    exp_t   exp_q[$];
    longint outs[$];

    // Compare observed against expected and report a mismatch.
    task automatic chk(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Reference: filter one sample given the previous one.
    function automatic exp_t golden(input longint x, input longint xp);
        exp_t   e;
        longint acc, q;
        acc = 1690 * x + (-666) * xp;
        q   = acc / 1024;                       // SV division truncates toward zero
        e.sat = 1'b0;
        if (q > 64'sd2147483647) begin
            q = 64'sd2147483647; e.sat = 1'b1;
        end else if (q < -64'sd2147483648) begin
            q = -64'sd2147483648; e.sat = 1'b1;
        end
        e.val = q;
        e.pop_cyc = 0;
        return e;
    endfunction

    task automatic clear_model();
        src.delete();
        exp_q.delete();
        outs.delete();
        mx_prev = 0;
        sat_exp = 1'b0;
        pops = 0;
        writes = 0;
    endtask

    task automatic do_reset();
        in_empty   = 1'b1;
        out_full   = 1'b0;
        full_force = 1'b0;
        rand_full  = 1'b0;
        bursty     = 1'b0;
        check_lat  = 1'b0;
        reset_n    = 1'b0;
        clear_model();
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    // One clock: drive after the edge, observe and update the model at negedge.
    task automatic step_cycle();
        exp_t e;
        @(posedge clock);
        #1;
        cyc++;
        if (src.size() > 0 && !(bursty && $urandom_range(0, 1) == 0)) begin
            in_empty = 1'b0;
            din      = src[0];
        end else begin
            in_empty = 1'b1;
            din      = $urandom;
        end
        out_full = full_force ? 1'b1 : (rand_full ? 1'($urandom_range(0, 1)) : 1'b0);
        @(negedge clock);
        if (in_rd_en) begin
            e = golden(longint'($signed(din)), mx_prev);
            e.pop_cyc = cyc;
            exp_q.push_back(e);
            mx_prev = longint'($signed(din));
            void'(src.pop_front());
            pops++;
        end
        if (out_wr_en) begin
            writes++;
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 1, 0);
            end else begin
                e = exp_q.pop_front();
                sat_exp = sat_exp | e.sat;
                chk("dout", longint'($signed(dout)), e.val);
                chk("sat_flag", longint'(sat_flag), longint'(sat_exp));
                if (check_lat) chk("latency", cyc - e.pop_cyc, 2);
                outs.push_back(longint'($signed(dout)));
            end
        end
    endtask

    task automatic drain(input int max_cyc);
        int n = 0;
        while ((src.size() > 0 || exp_q.size() > 0) && n < max_cyc) begin
            step_cycle();
            n++;
        end
        if (src.size() > 0 || exp_q.size() > 0)
            chk("drain_timeout", src.size() + exp_q.size(), 0);
    endtask

    initial begin
        longint held;
        int     win_pops;
        reset_n  = 1'b0;
        din      = 32'd0;
        in_empty = 1'b1;
        out_full = 1'b0;
        do_reset();

        // Reset state
        chk("rst_dout", longint'(dout), 0);
        chk("rst_wr_en", longint'(out_wr_en), 0);
        chk("rst_sat", longint'(sat_flag), 0);
        chk("rst_rd_en", longint'(in_rd_en), 0);

        // Step response with latency check
        check_lat = 1'b1;
        src = '{32'd1024, 32'd1024, 32'd1024};
        drain(50);
        chk("step_count", outs.size(), 3);
        if (outs.size() == 3) begin
            chk("step0", outs[0], 1690);
            chk("step1", outs[1], 1024);
            chk("step2", outs[2], 1024);
        end

        // Negative truncation toward zero
        do_reset();
        src = '{32'hFFFF_FFFF, 32'd0};
        drain(50);
        chk("neg_count", outs.size(), 2);
        if (outs.size() == 2) begin
            chk("neg_trunc", outs[0], -1);
            chk("neg_zero", outs[1], 0);
        end

        // Saturation, both rails, sticky flag
        do_reset();
        src = '{32'h7FFF_FFFF, 32'h8000_0000};
        drain(50);
        chk("sat_count", outs.size(), 2);
        if (outs.size() == 2) begin
            chk("sat_hi", outs[0], 64'sd2147483647);
            chk("sat_lo", outs[1], -64'sd2147483648);
        end
        repeat (5) step_cycle();
        chk("sat_sticky", longint'(sat_flag), 1);

        // Backpressure: out_full held for 5 cycles mid-stream
        do_reset();
        for (int k = 1; k <= 8; k++) src.push_back(32'(k));
        held = 0;
        win_pops = 0;
        for (int c = 0; c < 60 && (src.size() > 0 || exp_q.size() > 0); c++) begin
            full_force = (c >= 4 && c < 9);
            step_cycle();
            if (c == 4) held = longint'($signed(dout));
            if (c >= 5 && c < 9) chk("bp_dout_hold", longint'($signed(dout)), held);
            if (c >= 4 && c < 9 && in_rd_en) win_pops++;
            if (c == 6) chk("bp_rd_en_low", longint'(in_rd_en), 0);
        end
        full_force = 1'b0;
        chk("bp_window_pops_le1", longint'(win_pops <= 1), 1);
        chk("bp_writes", writes, 8);
        chk("bp_outs", outs.size(), 8);
        for (int k = 0; k < outs.size() && k < 8; k++) chk("bp_value", outs[k], k + 1);

        // Bursty input and random backpressure over 100 samples
        do_reset();
        for (int k = 0; k < 100; k++) begin
            if ($urandom_range(0, 3) == 0) src.push_back($urandom);
            else src.push_back(32'($signed($urandom_range(0, 200000)) - 100000));
        end
        bursty = 1'b1;
        rand_full = 1'b1;
        drain(2000);
        chk("burst_writes", writes, 100);
        bursty = 1'b0;
        rand_full = 1'b0;

        // Reset mid-stream with both stages valid
        do_reset();
        src = '{32'h7FFF_FFFF, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6};
        repeat (4) step_cycle();
        chk("pre_rst_sat", longint'(sat_flag), 1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_wr_en", longint'(out_wr_en), 0);
        chk("mid_rst_dout", longint'(dout), 0);
        chk("mid_rst_sat", longint'(sat_flag), 0);
        do_reset();
        src = '{32'd1024};
        drain(50);
        chk("post_rst_count", outs.size(), 1);
        if (outs.size() == 1) chk("post_rst_first", outs[0], 1690);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
